router_pkt_tx: RTL

//  Packet source for router_top: buffers payload bytes from a host, then serialises a packet

---
 rtl/router_pkt_tx_if.sv | 19 +
 rtl/router_pkt_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx_if.sv
// Router-side link of the packet transmitter:
// framed byte stream out, busy back-pressure in.
interface router_pkt_tx_if;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       busy;

  modport master (
    output pkt_valid,
    output data_out,
    input  busy
  );

  modport slave (
    input  pkt_valid,
    input  data_out,
    output busy
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Host-side packet source: buffers payload bytes, then sends
// header / payload / parity to the router, stalling on busy.
module router_pkt_tx #(
  parameter int BUF_AW = 6,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  input  logic              i_start,
  input  logic [1:0]        i_cmd_addr,
  input  logic [5:0]        i_cmd_len,
  input  logic              i_inj_err,
  router_pkt_tx_if.master   rt,
  output logic              o_ready,
  output logic              o_tx_done,
  output logic              o_cmd_err,
  output logic              o_buf_full,
  output logic [BUF_AW:0]   o_buf_count,
  output logic [15:0]       o_pkt_cnt
);
  localparam int DEPTH = 1 << BUF_AW;
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BUF_AW:0] FULL = (BUF_AW+1)'(DEPTH);

  // S_CMD is the one-cycle load slot between accept and header
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_HDR, S_PAY, S_PAR, S_GAPW
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_mem [DEPTH];
  logic [BUF_AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [BUF_AW:0]     r_count, w_count_nxt;
  logic [1:0]          r_addr;
  logic [5:0]          r_len, r_rem;
  logic [7:0]          r_par, w_par_nxt;
  logic [GW-1:0]       r_gap;
  logic                r_pkt_valid, r_ready, r_tx_done;
  logic                r_cmd_err, r_full;
  logic [7:0]          r_data;
  logic [15:0]         r_pkt_cnt;

  logic       w_try, w_bad, w_accept, w_reject;
  logic       w_consume, w_pop, w_push;
  logic       w_pv_nxt, w_tx_done_nxt;
  logic [7:0] w_data_nxt;

  assign w_try    = (r_state == S_IDLE) && i_start;
  assign w_bad    = (i_cmd_addr == 2'd3) ||
                    ((BUF_AW+1)'(i_cmd_len) > r_count);
  assign w_accept = w_try && !w_bad;
  assign w_reject = w_try && w_bad;

  assign w_consume = !rt.busy &&
                     (r_state inside {S_HDR, S_PAY, S_PAR});
  assign w_pop     = w_consume && (r_state == S_PAY);
  assign w_push    = i_wr_en && (r_count != FULL);
  assign w_rd_nxt  = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_comb begin
    w_par_nxt = r_par;
    if (w_accept)
      w_par_nxt = {i_cmd_len, i_cmd_addr} ^ {7'b0, i_inj_err};
    else if (w_pop)
      w_par_nxt = r_par ^ r_mem[r_rd_ptr];
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_CMD;
      S_CMD:  w_state_nxt = S_HDR;
      S_HDR:
        if (w_consume)
          w_state_nxt = (r_len != 6'd0) ? S_PAY : S_PAR;
      S_PAY:
        if (w_consume && r_rem == 6'd1) w_state_nxt = S_PAR;
      S_PAR:
        if (w_consume)
          w_state_nxt = (GAP == 0) ? S_IDLE : S_GAPW;
      S_GAPW: if (r_gap == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so a held
  // state under busy naturally holds pkt_valid/data_out.
  always_comb begin
    w_pv_nxt      = 1'b0;
    w_data_nxt    = 8'd0;
    w_tx_done_nxt = w_consume && (r_state == S_PAR);
    unique case (w_state_nxt)
      S_HDR: begin
        w_pv_nxt   = 1'b1;
        w_data_nxt = {r_len, r_addr};
      end
      S_PAY: begin
        w_pv_nxt   = 1'b1;
        w_data_nxt = r_mem[w_rd_nxt];
      end
      S_PAR:   w_data_nxt = w_par_nxt;
      default: w_data_nxt = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_par       <= '0;
      r_gap       <= '0;
      r_pkt_valid <= 1'b0;
      r_data      <= '0;
      r_ready     <= 1'b1;
      r_tx_done   <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == FULL);
      r_par    <= w_par_nxt;
      if (w_accept) begin
        r_addr <= i_cmd_addr;
        r_len  <= i_cmd_len;
        r_rem  <= i_cmd_len;
      end else if (w_pop) begin
        r_rem <= r_rem - 1'b1;
      end
      if (r_state == S_PAR)
        r_gap <= GW'(GAP - 1);
      else if (r_state == S_GAPW && r_gap != '0)
        r_gap <= r_gap - 1'b1;
      r_pkt_valid <= w_pv_nxt;
      r_data      <= w_data_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_tx_done   <= w_tx_done_nxt;
      r_cmd_err   <= w_reject;
      if (w_tx_done_nxt) r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  assign rt.pkt_valid  = r_pkt_valid;
  assign rt.data_out   = r_data;
  assign o_ready       = r_ready;
  assign o_tx_done     = r_tx_done;
  assign o_cmd_err     = r_cmd_err;
  assign o_buf_full    = r_full;
  assign o_buf_count   = r_count;
  assign o_pkt_cnt     = r_pkt_cnt;
endmodule
